ps2_kbd_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_frame_ser.sv | 87 ++++++++
 rtl/ps2_kbd_tx.sv | 144 ++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and parity helper for the PS/2 keyboard transmitter.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  // Bit-level line states of one frame plus the inter-frame gap (one-hot).
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_BIT_HI = 4'b0010,
    ST_BIT_LO = 4'b0100,
    ST_GAP    = 4'b1000
  } ps2_state_e;

  // Byte-sequence level states owned by the top (one-hot).
  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'b001,
    SEQ_FRAME = 3'b010,
    SEQ_GAP   = 3'b100
  } seq_state_e;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_frame_ser.sv
// Serialises one byte as an 11-bit PS/2 frame: start 0, data LSB first, odd parity, stop 1.
module ps2_frame_ser
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       frame_done,
  output ps2_state_e state
);

  localparam int              PW       = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0]   PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e                state_q, state_nxt;
  logic [PW-1:0]             phase_q;
  logic [3:0]                bit_idx_q;
  logic [PS2_FRAME_BITS-1:0] frame_q;
  logic                      data_q;
  logic                      phase_last;
  logic                      bit_adv;

  assign phase_last = (phase_q == PH_LAST);

  always_comb begin
    state_nxt  = state_q;
    frame_done = 1'b0;
    bit_adv    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_nxt = ST_BIT_HI;
      end
      ST_BIT_HI: begin
        if (phase_last) state_nxt = ST_BIT_LO;
      end
      ST_BIT_LO: begin
        if (phase_last) begin
          if (bit_idx_q == LAST_BIT) begin
            state_nxt  = ST_IDLE;
            frame_done = 1'b1;
          end else begin
            state_nxt = ST_BIT_HI;
            bit_adv   = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // frame_q[0] always holds the bit currently on the line; it shifts on each new BIT_HI.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      frame_q   <= '1;
      data_q    <= 1'b1;
    end else begin
      state_q <= state_nxt;
      if ((state_nxt != state_q) || (state_q == ST_IDLE)) phase_q <= '0;
      else                                               phase_q <= phase_q + PW'(1);
      if ((state_q == ST_IDLE) && start) begin
        frame_q   <= {1'b1, odd_parity(tx_byte), tx_byte, 1'b0};
        bit_idx_q <= '0;
        data_q    <= 1'b0;
      end else if (bit_adv) begin
        frame_q   <= {1'b1, frame_q[PS2_FRAME_BITS-1:1]};
        bit_idx_q <= bit_idx_q + 4'd1;
        data_q    <= frame_q[1];
      end else if (frame_done) begin
        data_q <= 1'b1;
      end
    end
  end

  assign ps2_clk  = (state_q != ST_BIT_LO);
  assign ps2_data = data_q;
  assign state    = state_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: make / F0-break sequences, framed and gapped.
// Define PS2_TX_EXTENDED_EN to prefix E0 when key_ext is set at accept.
//
// Handshake: a request transfers on the rising clk edge where key_valid & key_ready;
// key_ready is high only in IDLE and nothing is queued while busy.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV   = 8,
  parameter int FRAME_GAP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       key_release,
  input  logic       key_ext,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       tx_done
);

  localparam int            GW       = $clog2(FRAME_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP - 1);

  seq_state_e      seq_q, seq_nxt;
  logic [GW-1:0]   gap_q;
  logic [3:0][7:0] bytes_q, bytes_in;
  logic [1:0]      n_q, n_in;
  logic [1:0]      idx_q, next_idx;
  logic            pending;
  logic            ext_sel;
  logic            ser_start;
  logic [7:0]      ser_byte;
  logic            frame_done;
  ps2_state_e      ser_state;
  logic            ser_idle;

`ifdef PS2_TX_EXTENDED_EN
  assign ext_sel = key_ext;
`else
  logic unused_key_ext;
  assign unused_key_ext = key_ext;
  assign ext_sel        = 1'b0;
`endif

  // Expand the request into its byte list at accept time.
  always_comb begin
    bytes_in = {8'h00, 8'h00, 8'h00, key_code};
    n_in     = 2'd1;
    if (ext_sel && key_release) begin
      bytes_in[0] = PS2_EXT;
      bytes_in[1] = PS2_BREAK;
      bytes_in[2] = key_code;
      n_in        = 2'd3;
    end else if (ext_sel) begin
      bytes_in[0] = PS2_EXT;
      bytes_in[1] = key_code;
      n_in        = 2'd2;
    end else if (key_release) begin
      bytes_in[0] = PS2_BREAK;
      bytes_in[1] = key_code;
      n_in        = 2'd2;
    end
  end

  assign next_idx = idx_q + 2'd1;
  assign pending  = (next_idx < n_q);
  assign ser_idle = (ser_state == ST_IDLE);

  always_comb begin
    seq_nxt   = seq_q;
    ser_start = 1'b0;
    ser_byte  = bytes_q[next_idx];
    tx_done   = 1'b0;
    unique case (seq_q)
      SEQ_IDLE: begin
        if (key_valid) begin
          seq_nxt   = SEQ_FRAME;
          ser_start = 1'b1;
          ser_byte  = bytes_in[0];
        end
      end
      SEQ_FRAME: begin
        if (frame_done) seq_nxt = SEQ_GAP;
      end
      SEQ_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (pending && ser_idle) begin
            seq_nxt   = SEQ_FRAME;
            ser_start = 1'b1;
          end else begin
            seq_nxt = SEQ_IDLE;
            tx_done = 1'b1;
          end
        end
      end
      default: seq_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q   <= SEQ_IDLE;
      gap_q   <= '0;
      bytes_q <= '0;
      n_q     <= '0;
      idx_q   <= '0;
    end else begin
      seq_q <= seq_nxt;
      if ((seq_q == SEQ_GAP) && (seq_nxt == SEQ_GAP)) gap_q <= gap_q + GW'(1);
      else                                             gap_q <= '0;
      if ((seq_q == SEQ_IDLE) && key_valid) begin
        bytes_q <= bytes_in;
        n_q     <= n_in;
        idx_q   <= '0;
      end else if ((seq_q == SEQ_GAP) && ser_start) begin
        idx_q <= next_idx;
      end else if (tx_done) begin
        n_q   <= '0;
        idx_q <= '0;
      end
    end
  end

  assign key_ready = (seq_q == SEQ_IDLE);
  assign busy      = ~key_ready;

  ps2_frame_ser #(
    .CLK_DIV(CLK_DIV)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .start     (ser_start),
    .tx_byte   (ser_byte),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .frame_done(frame_done),
    .state     (ser_state)
  );

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: two instances (CLK_DIV=4/GAP=16 and CLK_DIV=1/GAP=1).
module tb_ps2_kbd_tx;

  localparam int CA = 4;
  localparam int GA = 16;
  localparam int CB = 1;
  localparam int GB = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] code_a = 8'h00, code_b = 8'h00;
  logic rel_a = 1'b0, rel_b = 1'b0, ext_a = 1'b0, ext_b = 1'b0;
  logic kv_a = 1'b0, kv_b = 1'b0;
  logic kr_a, pc_a, pd_a, busy_a, td_a;
  logic kr_b, pc_b, pd_b, busy_b, td_b;

  ps2_kbd_tx #(.CLK_DIV(CA), .FRAME_GAP(GA)) dut_a (
    .clk(clk), .rst(rst), .key_code(code_a), .key_release(rel_a), .key_ext(ext_a),
    .key_valid(kv_a), .key_ready(kr_a), .ps2_clk(pc_a), .ps2_data(pd_a),
    .busy(busy_a), .tx_done(td_a)
  );

  ps2_kbd_tx #(.CLK_DIV(CB), .FRAME_GAP(GB)) dut_b (
    .clk(clk), .rst(rst), .key_code(code_b), .key_release(rel_b), .key_ext(ext_b),
    .key_valid(kv_b), .key_ready(kr_b), .ps2_clk(pc_b), .ps2_data(pd_b),
    .busy(busy_b), .tx_done(td_b)
  );

  // scoreboard
  logic [10:0] exp_q[$];
  int          exp_done_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  logic        pclk[2], pdat[2], arm[2], gmeas[2];
  int          nbits[2], fstart[2], ffall[2], grise[2];
  logic [10:0] shreg[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b);
    int   ones;
    logic p;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    p = ((ones % 2) == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic push_seq(input logic [7:0] code, input logic rel, input logic ext,
                          input int acc, input int cdiv, input int gap);
    int   n;
    logic e;
`ifdef PS2_TX_EXTENDED_EN
    e = ext;
`else
    e = 1'b0 & ext;
`endif
    n = 1;
    if (e) begin exp_q.push_back(mk_frame(8'hE0)); n++; end
    if (rel) begin exp_q.push_back(mk_frame(8'hF0)); n++; end
    exp_q.push_back(mk_frame(code));
    exp_done_q.push_back(acc + n * (22 * cdiv + gap));
  endtask

  // Line monitor: frames decoded from data sampled at each ps2_clk fall.
  task automatic mon(input int id, input int cdiv, input int gap,
                     input logic pc, input logic pd, input logic td);
    if (rst) begin
      nbits[id] = 0; arm[id] = 1'b0; gmeas[id] = 1'b0; pclk[id] = 1'b1; pdat[id] = 1'b1;
    end else begin
      if (nbits[id] == 0 && pdat[id] && !pd && pc) begin
        fstart[id] = cyc;
        if (gmeas[id]) begin
          check("gap_len", cyc - grise[id], gap);
          gmeas[id] = 1'b0;
        end
      end
      if (!pc && !pclk[id] && (pd !== pdat[id])) check("data_hold", pd, pdat[id]);
      if (pclk[id] && !pc) begin
        if (nbits[id] == 0) ffall[id] = cyc;
        shreg[id] = {pd, shreg[id][10:1]};
        nbits[id]++;
        if (nbits[id] == 11) begin
          check("fall_span", cyc - ffall[id], 20 * cdiv);
          if (exp_q.size() == 0) check("frame_unexpected", exp_q.size(), 1);
          else check("frame", shreg[id], exp_q.pop_front());
          nbits[id] = 0;
          arm[id]   = 1'b1;
        end
      end
      if (!pclk[id] && pc && arm[id]) begin
        check("frame_len", cyc - fstart[id], 22 * cdiv);
        arm[id]   = 1'b0;
        grise[id] = cyc;
        gmeas[id] = 1'b1;
      end
      if (td) begin
        if (exp_done_q.size() == 0) check("done_unexpected", exp_done_q.size(), 1);
        else check("done_cycle", cyc, exp_done_q.pop_front());
        gmeas[id] = 1'b0;
      end
      pclk[id] = pc;
      pdat[id] = pd;
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    mon(0, CA, GA, pc_a, pd_a, td_a);
    mon(1, CB, GB, pc_b, pd_b, td_b);
  end

  // driver tasks (called at a negedge)
  task automatic send(input int id, input logic [7:0] code, input logic rel, input logic ext,
                      output int acc);
    logic rdy;
    acc = -1;
    if (id == 0) begin code_a = code; rel_a = rel; ext_a = ext; kv_a = 1'b1; end
    else         begin code_b = code; rel_b = rel; ext_b = ext; kv_b = 1'b1; end
    for (int i = 0; i < 1000; i++) begin
      rdy = (id == 0) ? kr_a : kr_b;
      if (rdy) break;
      @(negedge clk);
    end
    rdy = (id == 0) ? kr_a : kr_b;
    if (!rdy) check("accept_timeout", rdy, 1);
    else begin
      acc = cyc;
      if (id == 0) push_seq(code, rel, ext, acc, CA, GA);
      else         push_seq(code, rel, ext, acc, CB, GB);
    end
    @(negedge clk);
    if (id == 0) kv_a = 1'b0; else kv_b = 1'b0;
  endtask

  task automatic drain(input int id);
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && exp_done_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || exp_done_q.size() != 0) begin
      check("drain_timeout", exp_q.size() + exp_done_q.size(), 0);
      exp_q.delete();
      exp_done_q.delete();
    end else begin
      check("done_pulse", (id == 0) ? td_a : td_b, 1);
      check("ready_in_done_cycle", (id == 0) ? kr_a : kr_b, 0);
      @(negedge clk);
      check("ready_after_done", (id == 0) ? kr_a : kr_b, 1);
      check("done_one_cycle", (id == 0) ? td_a : td_b, 0);
    end
  endtask

  initial begin
    int acc, acc2, target;
    for (int i = 0; i < 2; i++) begin
      pclk[i] = 1'b1; pdat[i] = 1'b1; arm[i] = 1'b0; gmeas[i] = 1'b0;
      nbits[i] = 0; fstart[i] = 0; ffall[i] = 0; grise[i] = 0; shreg[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", pc_a, 1);
    check("rst_ps2_data", pd_a, 1);
    check("rst_key_ready", kr_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_tx_done", td_a, 0);
    check("rst_b_lines", {pc_b, pd_b, kr_b}, 3'b111);
    rst = 1'b0;
    @(negedge clk);

    // make 0x1C
    send(0, 8'h1C, 1'b0, 1'b0, acc);
    drain(0);

    // release 0x12
    send(0, 8'h12, 1'b1, 1'b0, acc);
    drain(0);

    // backpressure: valid held through busy with a new code
    code_a = 8'h1C; rel_a = 1'b0; ext_a = 1'b0; kv_a = 1'b1;
    acc = cyc;
    check("bp_first_ready", kr_a, 1);
    push_seq(8'h1C, 1'b0, 1'b0, acc, CA, GA);
    @(negedge clk);
    code_a = 8'h32;
    check("bp_ready_low", kr_a, 0);
    check("bp_busy", busy_a, 1);
    for (int i = 0; i < 300; i++) begin
      if (kr_a) break;
      @(negedge clk);
    end
    check("bp_accept_cycle", cyc, acc + 22 * CA + GA + 1);
    acc2 = cyc;
    push_seq(8'h32, 1'b0, 1'b0, acc2, CA, GA);
    @(negedge clk);
    kv_a = 1'b0;
    drain(0);

    // reset during data bit 4 of 0x1C
    send(0, 8'h1C, 1'b0, 1'b0, acc);
    target = acc + 1 + 2 * CA * 5 + 1;
    for (int i = 0; i < 200; i++) begin
      if (cyc >= target) break;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    check("midrst_ps2_clk", pc_a, 1);
    check("midrst_ps2_data", pd_a, 1);
    check("midrst_key_ready", kr_a, 1);
    check("midrst_tx_done", td_a, 0);
    repeat (150) @(negedge clk);
    send(0, 8'h45, 1'b0, 1'b0, acc);
    drain(0);

    // CLK_DIV=1, FRAME_GAP=1 boundary
    send(1, 8'h00, 1'b0, 1'b0, acc);
    drain(1);

    // extended release 0x75 (E0 prefix only with the feature enabled)
    send(0, 8'h75, 1'b1, 1'b1, acc);
    drain(0);

    // a few random requests
    for (int k = 0; k < 4; k++) begin
      send(0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      drain(0);
    end
    for (int k = 0; k < 3; k++) begin
      send(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      drain(1);
    end

    repeat (5) @(negedge clk);
    check("final_exp_empty", exp_q.size() + exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
